// File: rtl/pipe_arb_pkg.sv
// Shared encodings for the MEM-stage data-port arbiter between the CPU pipeline and the DMA/debug requester.
package pipe_arb_pkg;

  typedef enum logic {
    ARB_CPU_PRI = 1'b0,
    ARB_DMA_PRI = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

endpackage

// File: rtl/pipe_arb_fsm.sv
// Priority state, starvation and burst counters, and the combinational owner decision
// for the shared data-memory port.
module pipe_arb_fsm
  import pipe_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 3,
  parameter int BURST_MAX    = 2
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   cpu_req,
  input  logic   dma_req,
  output owner_e owner
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIMIT);
  localparam logic [BW-1:0] BURST_TOP  = BW'(BURST_MAX);

  arb_state_e    state_reg, state_next;
  logic [SW-1:0] starve_reg, starve_next;
  logic [BW-1:0] burst_reg, burst_next;
  logic          contended;
  logic [BW-1:0] burst_inc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg  <= ARB_CPU_PRI;
      starve_reg <= '0;
      burst_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      starve_reg <= starve_next;
      burst_reg  <= burst_next;
    end
  end

  always_comb begin
    owner       = OWN_CPU;
    state_next  = state_reg;
    starve_next = starve_reg;
    burst_next  = burst_reg;
    contended   = cpu_req & dma_req;
    burst_inc   = burst_reg + BW'(1);

    if (dma_req && (!cpu_req || state_reg == ARB_DMA_PRI || starve_reg == STARVE_TOP)) begin
      owner = OWN_DMA;
    end

    case (state_reg)
      ARB_CPU_PRI: begin
        if (!contended) begin
          starve_next = '0;
        end else if (owner == OWN_DMA) begin
          starve_next = '0;
          // A one-grant burst is already complete, so priority never leaves the CPU.
          if (BW'(1) >= BURST_TOP) begin
            burst_next = '0;
          end else begin
            state_next = ARB_DMA_PRI;
            burst_next = BW'(1);
          end
        end else begin
          starve_next = starve_reg + SW'(1);
        end
      end
      ARB_DMA_PRI: begin
        if (dma_req) begin
          if (burst_inc >= BURST_TOP) begin
            state_next = ARB_CPU_PRI;
            burst_next = '0;
          end else begin
            burst_next = burst_inc;
          end
        end else begin
          state_next  = ARB_CPU_PRI;
          burst_next  = '0;
          starve_next = '0;
        end
      end
      default: begin
        state_next  = ARB_CPU_PRI;
        starve_next = '0;
        burst_next  = '0;
      end
    endcase
  end

endmodule

// File: rtl/pipe_dmem_arbiter.sv
// Shares the MEM-stage data port between the CPU and a DMA/debug requester; stalls the
// pipeline when the DMA takes the port from a CPU access and registers DMA read data.
module pipe_dmem_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 3,
  parameter int BURST_MAX    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  owner_e      owner;
  logic        dma_own;
  logic        dma_rvalid_reg;
  logic [31:0] dma_rdata_reg;

  pipe_arb_fsm #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .BURST_MAX   (BURST_MAX)
  ) u_fsm (
    .clock  (clock),
    .reset  (reset),
    .cpu_req(cpu_req),
    .dma_req(dma_req),
    .owner  (owner)
  );

  // Reset masks every side-effecting output so nothing reaches the RAM while held.
  assign dma_own   = (owner == OWN_DMA) & ~reset;
  assign dma_gnt   = dma_own;
  assign cpu_stall = cpu_req & dma_own;
  assign cpu_rdata = ram_rdata;

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    if (dma_own) begin
      ram_we    = dma_we;
      ram_addr  = dma_addr;
      ram_wdata = dma_wdata;
    end else if (!reset) begin
      ram_we = cpu_req & cpu_we;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dma_rvalid_reg <= 1'b0;
      dma_rdata_reg  <= '0;
    end else begin
      dma_rvalid_reg <= dma_own & ~dma_we;
      if (dma_own && !dma_we) begin
        dma_rdata_reg <= ram_rdata;
      end
    end
  end

  assign dma_rvalid = dma_rvalid_reg;
  assign dma_rdata  = dma_rdata_reg;

endmodule

// File: tb/tb_pipe_dmem_arbiter.sv
// Directed bench for pipe_dmem_arbiter: a vector table for single-requester traffic plus
// hand sequences for contention, early DMA release, mid-burst reset and the 1/1 parameter set.
module tb_pipe_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [31:0] cpu_rdata, dma_rdata, ram_addr, ram_wdata, ram_rdata;
  logic        cpu_stall, dma_gnt, dma_rvalid, ram_we;

  logic [31:0] b_cpu_rdata, b_dma_rdata, b_ram_addr, b_ram_wdata;
  logic        b_cpu_stall, b_dma_gnt, b_dma_rvalid, b_ram_we;

  logic [31:0] mem [0:255];

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  pipe_dmem_arbiter dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  pipe_dmem_arbiter #(.STARVE_LIMIT(1), .BURST_MAX(1)) dut_alt (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(b_dma_gnt), .dma_rvalid(b_dma_rvalid), .dma_rdata(b_dma_rdata),
    .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_rdata(32'h0)
  );

  // Data memory model: combinational read, write at the rising edge.
  assign ram_rdata = mem[ram_addr[9:2]];
  always @(posedge clock) if (ram_we) mem[ram_addr[9:2]] <= ram_wdata;

  typedef struct {
    logic        cr, cw;
    logic [31:0] ca, cd;
    logic        dr, dw;
    logic [31:0] da, dd;
    logic        e_we;
    logic [31:0] e_addr;
    logic        e_stall, e_gnt, e_rvalid;
    logic [31:0] e_rdata, e_cpu_rdata;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                        input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
    @(posedge clock);
    #1;
    set_in(cr, cw, ca, cd, dr, dw, da, dd);
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // One contended cycle (CPU load of 0x40, DMA read of 0x20), checking the default DUT's owner.
  task automatic contend(input string tag, input int idx, input logic exp_dma);
    drive(1, 0, 32'h40, 0, 1, 0, 32'h20, 0);
    $display("%s cycle %0d: dma_gnt=%0b cpu_stall=%0b ram_addr=%h", tag, idx, dma_gnt, cpu_stall, ram_addr);
    chk({tag, "_gnt"}, {31'b0, dma_gnt}, {31'b0, exp_dma});
    chk({tag, "_stall"}, {31'b0, cpu_stall}, {31'b0, exp_dma});
  endtask

  logic exp_main [12];
  logic exp_alt  [12];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8] = 32'h0000CAFE;

    //        cr cw ca     cd       dr dw da     dd      | we addr   st gnt rv rdata         cpu_rdata
    vecs[0] = '{1, 1, 32'h10, 32'h1234, 0, 0, 32'h0,  32'h0,    1, 32'h10, 0, 0, 0, 32'h0,    32'h0};
    vecs[1] = '{0, 0, 32'h0,  32'h0,    0, 0, 32'h0,  32'h0,    0, 32'h0,  0, 0, 0, 32'h0,    32'h0};
    vecs[2] = '{0, 0, 32'h0,  32'h0,    1, 0, 32'h20, 32'h0,    0, 32'h20, 0, 1, 0, 32'h0,    32'hCAFE};
    vecs[3] = '{0, 0, 32'h0,  32'h0,    0, 0, 32'h0,  32'h0,    0, 32'h0,  0, 0, 1, 32'hCAFE, 32'h0};
    vecs[4] = '{0, 0, 32'h0,  32'h0,    0, 0, 32'h0,  32'h0,    0, 32'h0,  0, 0, 0, 32'hCAFE, 32'h0};
    vecs[5] = '{0, 0, 32'h0,  32'h0,    1, 1, 32'h24, 32'hBEEF, 1, 32'h24, 0, 1, 0, 32'hCAFE, 32'h0};
    vecs[6] = '{0, 0, 32'h0,  32'h0,    1, 0, 32'h24, 32'h0,    0, 32'h24, 0, 1, 0, 32'hCAFE, 32'hBEEF};
    vecs[7] = '{1, 0, 32'h24, 32'h0,    0, 0, 32'h0,  32'h0,    0, 32'h24, 0, 0, 1, 32'hBEEF, 32'hBEEF};
    vecs[8] = '{1, 0, 32'h10, 32'h0,    0, 0, 32'h0,  32'h0,    0, 32'h10, 0, 0, 0, 32'hBEEF, 32'h1234};

    exp_main = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0};
    exp_alt  = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

    // Reset state, with both requesters active so the forced-zero outputs are meaningful.
    set_in(1, 1, 32'h10, 32'h5, 1, 1, 32'h20, 32'h6);
    #7;
    $display("reset: dma_gnt=%0b cpu_stall=%0b ram_we=%0b dma_rvalid=%0b", dma_gnt, cpu_stall, ram_we, dma_rvalid);
    chk("reset_gnt", {31'b0, dma_gnt}, 32'h0);
    chk("reset_stall", {31'b0, cpu_stall}, 32'h0);
    chk("reset_ram_we", {31'b0, ram_we}, 32'h0);
    chk("reset_rvalid", {31'b0, dma_rvalid}, 32'h0);
    chk("reset_rdata", dma_rdata, 32'h0);
    do_reset();

    // Single-requester traffic from the vector table.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd, vecs[i].dr, vecs[i].dw, vecs[i].da, vecs[i].dd);
      $display("vec %0d: ram_we=%0b ram_addr=%h gnt=%0b stall=%0b rvalid=%0b dma_rdata=%h cpu_rdata=%h",
               i, ram_we, ram_addr, dma_gnt, cpu_stall, dma_rvalid, dma_rdata, cpu_rdata);
      chk($sformatf("vec%0d_ram_we", i), {31'b0, ram_we}, {31'b0, vecs[i].e_we});
      chk($sformatf("vec%0d_ram_addr", i), ram_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d_stall", i), {31'b0, cpu_stall}, {31'b0, vecs[i].e_stall});
      chk($sformatf("vec%0d_gnt", i), {31'b0, dma_gnt}, {31'b0, vecs[i].e_gnt});
      chk($sformatf("vec%0d_rvalid", i), {31'b0, dma_rvalid}, {31'b0, vecs[i].e_rvalid});
      chk($sformatf("vec%0d_dma_rdata", i), dma_rdata, vecs[i].e_rdata);
      chk($sformatf("vec%0d_cpu_rdata", i), cpu_rdata, vecs[i].e_cpu_rdata);
      if (vecs[i].e_we) chk($sformatf("vec%0d_ram_wdata", i), ram_wdata, vecs[i].cr ? vecs[i].cd : vecs[i].dd);
    end

    // Continuous contention: default pattern on one DUT, strict alternation on the 1/1 DUT.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      contend("contend", i, exp_main[i]);
      chk($sformatf("contend%0d_addr", i), ram_addr, exp_main[i] ? 32'h20 : 32'h40);
      chk($sformatf("alt%0d_gnt", i), {31'b0, b_dma_gnt}, {31'b0, exp_alt[i]});
    end

    // DMA drops its request on the first DMA-priority cycle.
    do_reset();
    for (int i = 0; i < 4; i++) contend("drop_pre", i, exp_main[i]);
    drive(1, 0, 32'h40, 0, 0, 0, 32'h20, 0);
    $display("drop cycle: dma_gnt=%0b cpu_stall=%0b ram_addr=%h", dma_gnt, cpu_stall, ram_addr);
    chk("drop_gnt", {31'b0, dma_gnt}, 32'h0);
    chk("drop_stall", {31'b0, cpu_stall}, 32'h0);
    chk("drop_addr", ram_addr, 32'h40);
    for (int i = 0; i < 4; i++) contend("drop_post", i, exp_main[i]);

    // Reset in the middle of a DMA-priority read cycle.
    do_reset();
    for (int i = 0; i < 4; i++) contend("rst_pre", i, exp_main[i]);
    contend("rst_burst", 4, 1'b1);
    chk("rst_burst_rvalid", {31'b0, dma_rvalid}, 32'h1);
    chk("rst_burst_rdata", dma_rdata, 32'hCAFE);
    #1;
    reset = 1'b1;
    #1;
    $display("mid-burst reset: dma_gnt=%0b cpu_stall=%0b dma_rvalid=%0b", dma_gnt, cpu_stall, dma_rvalid);
    chk("rst_mid_gnt", {31'b0, dma_gnt}, 32'h0);
    chk("rst_mid_stall", {31'b0, cpu_stall}, 32'h0);
    chk("rst_mid_rvalid", {31'b0, dma_rvalid}, 32'h0);
    chk("rst_mid_ram_we", {31'b0, ram_we}, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    $display("rst_post cycle 0: dma_gnt=%0b cpu_stall=%0b", dma_gnt, cpu_stall);
    chk("rst_post0_gnt", {31'b0, dma_gnt}, 32'h0);
    for (int i = 1; i < 4; i++) contend("rst_post", i, exp_main[i]);

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
